sdr_wr_burst_feeder: RTL and testbench

Write-side data sequencer that sits directly upstream of the SDRAM data path stage. On each write command from the SDRAM command controller it pops a fixed-length burst of words from the show-ahead write FIFO and drives the data path's `DATAIN`/`DM` inputs. The data path registers `DQM` one cycle later than `DATAIN`, so this block presents each word's mask one cycle ahead of its data; mask and data then coincide at the SDRAM pins. When the FIFO runs dry mid-burst, the block masks the missing beats instead of stalling the burst.

---
 rtl/sdr_wr_burst_feeder.sv | 82 ++++++++
 tb/tb_sdr_wr_burst_feeder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_wr_burst_feeder.sv
// Write-side burst sequencer: pops a fixed-length burst from a show-ahead FIFO
// into the SDRAM data path, masking beats one cycle ahead of their data.
module sdr_wr_burst_feeder #(
  parameter int DSIZE = 32,
  parameter int LEN_W = 9
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               WR_START,
  input  logic [LEN_W-1:0]   WR_LEN,
  input  logic               WR_ABORT,
  input  logic [DSIZE-1:0]   FIFO_DATA,
  input  logic               FIFO_EMPTY,
  output logic               FIFO_RDREQ,
  output logic [DSIZE-1:0]   DATAIN,
  output logic [DSIZE/8-1:0] DM,
  output logic               BUSY,
  output logic               DONE,
  output logic               UNDERRUN,
  input  logic               UNDERRUN_CLR
);

  // state | meaning
  // IDLE  | no burst; DM all ones, no pops
  // BURST | one beat per cycle until rem reaches 1 or an abort arrives
  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic             beat;
  logic             pop;

  // An abort cancels the beat of its own cycle, so it must gate the pop directly.
  assign beat       = (state == BURST) && !WR_ABORT;
  assign pop        = beat && !FIFO_EMPTY;
  assign FIFO_RDREQ = pop;
  assign DM         = pop ? '0 : '1;
  assign BUSY       = (state == BURST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      rem      <= '0;
      DATAIN   <= '0;
      DONE     <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (WR_START && !WR_ABORT && (WR_LEN != '0)) begin
            rem   <= WR_LEN;
            state <= BURST;
          end
        end
        BURST: begin
          if (WR_ABORT) begin
            rem   <= '0;
            state <= IDLE;
          end else begin
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              state <= IDLE;
              DONE  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (pop)
        DATAIN <= FIFO_DATA;

      // A fresh underrun wins over a clear in the same cycle.
      if (beat && FIFO_EMPTY)
        UNDERRUN <= 1'b1;
      else if (UNDERRUN_CLR)
        UNDERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdr_wr_burst_feeder.sv
// Directed bench for sdr_wr_burst_feeder with a show-ahead FIFO model.
module tb_sdr_wr_burst_feeder;
  localparam int DSIZE = 32;
  localparam int LEN_W = 9;

  logic               CLK = 1'b0;
  logic               RESET_N;
  logic               WR_START;
  logic [LEN_W-1:0]   WR_LEN;
  logic               WR_ABORT;
  logic [DSIZE-1:0]   FIFO_DATA;
  logic               FIFO_EMPTY;
  logic               FIFO_RDREQ;
  logic [DSIZE-1:0]   DATAIN;
  logic [DSIZE/8-1:0] DM;
  logic               BUSY;
  logic               DONE;
  logic               UNDERRUN;
  logic               UNDERRUN_CLR;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] fmem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  logic        flush = 1'b0;
  int          p0;

  sdr_wr_burst_feeder #(.DSIZE(DSIZE), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .WR_START(WR_START), .WR_LEN(WR_LEN),
    .WR_ABORT(WR_ABORT), .FIFO_DATA(FIFO_DATA), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RDREQ(FIFO_RDREQ), .DATAIN(DATAIN), .DM(DM), .BUSY(BUSY),
    .DONE(DONE), .UNDERRUN(UNDERRUN), .UNDERRUN_CLR(UNDERRUN_CLR)
  );

  always #5 CLK = ~CLK;

  assign FIFO_EMPTY = (wr_ptr == rd_ptr);
  assign FIFO_DATA  = fmem[rd_ptr % 1024];

  always @(posedge CLK) begin
    if (flush)
      rd_ptr <= wr_ptr;
    else if (FIFO_RDREQ && !FIFO_EMPTY) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic push(input logic [31:0] d);
    fmem[wr_ptr % 1024] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET_N = 1'b0; WR_START = 1'b0; WR_LEN = '0; WR_ABORT = 1'b0; UNDERRUN_CLR = 1'b0;
    flush = 1'b1;
    #1;
    check("rst_datain", DATAIN, 0);
    check("rst_dm", DM, 4'hF);
    check("rst_rdreq", FIFO_RDREQ, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_underrun", UNDERRUN, 0);
    cyc(); cyc();
    RESET_N = 1'b1; flush = 1'b0;
    cyc();

    // Nominal 4-word burst
    for (int i = 0; i < 4; i++) push(32'hA000_0000 + i);
    WR_START = 1'b1; WR_LEN = 9'd4; #1;
    check("nom_idle_busy", BUSY, 0);
    check("nom_idle_rdreq", FIFO_RDREQ, 0);
    check("nom_idle_dm", DM, 4'hF);
    for (int i = 0; i < 4; i++) begin
      cyc(); WR_START = 1'b0; #1;
      check("nom_rdreq", FIFO_RDREQ, 1);
      check("nom_dm", DM, 4'h0);
      check("nom_busy", BUSY, 1);
      check("nom_done", DONE, 0);
      if (i > 0) check("nom_datain", DATAIN, 32'hA000_0000 + i - 1);
    end
    cyc();
    check("nom_last_datain", DATAIN, 32'hA000_0003);
    check("nom_done_pulse", DONE, 1);
    check("nom_busy_end", BUSY, 0);
    check("nom_dm_end", DM, 4'hF);
    check("nom_underrun", UNDERRUN, 0);
    cyc();
    check("nom_done_low", DONE, 0);
    check("nom_hold", DATAIN, 32'hA000_0003);

    // Underrun: B0, two empty beats, then B1, B2
    push(32'hB000_0000);
    WR_START = 1'b1; WR_LEN = 9'd5;
    cyc(); WR_START = 1'b0; #1;
    check("ur_dm0", DM, 4'h0);
    cyc();
    check("ur_dm1", DM, 4'hF);
    check("ur_rdreq1", FIFO_RDREQ, 0);
    check("ur_datain1", DATAIN, 32'hB000_0000);
    cyc();
    check("ur_dm2", DM, 4'hF);
    check("ur_datain2", DATAIN, 32'hB000_0000);
    cyc();
    push(32'hB000_0001); push(32'hB000_0002); #1;
    check("ur_dm3", DM, 4'h0);
    check("ur_datain3", DATAIN, 32'hB000_0000);
    cyc();
    check("ur_dm4", DM, 4'h0);
    check("ur_datain4", DATAIN, 32'hB000_0001);
    cyc();
    check("ur_datain5", DATAIN, 32'hB000_0002);
    check("ur_done", DONE, 1);
    check("ur_flag", UNDERRUN, 1);
    UNDERRUN_CLR = 1'b1;
    cyc(); UNDERRUN_CLR = 1'b0; #1;
    check("ur_cleared", UNDERRUN, 0);

    // Abort in beat 3 of an 8-word burst
    for (int i = 0; i < 8; i++) push(32'hC000_0000 + i);
    p0 = pop_cnt;
    WR_START = 1'b1; WR_LEN = 9'd8;
    cyc(); WR_START = 1'b0;
    cyc(); cyc();
    cyc(); WR_ABORT = 1'b1; #1;
    check("ab_rdreq", FIFO_RDREQ, 0);
    check("ab_dm", DM, 4'hF);
    check("ab_busy", BUSY, 1);
    cyc(); WR_ABORT = 1'b0; #1;
    check("ab_busy_low", BUSY, 0);
    check("ab_no_done", DONE, 0);
    check("ab_pops", pop_cnt - p0, 3);
    check("ab_datain", DATAIN, 32'hC000_0002);
    check("ab_fifo_left", wr_ptr - rd_ptr, 5);
    cyc();
    check("ab_no_done2", DONE, 0);
    flush = 1'b1; cyc(); flush = 1'b0;

    // Full page burst followed by a 1-word burst issued in the DONE cycle
    for (int i = 0; i < 257; i++) push(32'hD000_0000 + i);
    p0 = pop_cnt;
    WR_START = 1'b1; WR_LEN = 9'd256;
    for (int i = 0; i < 256; i++) begin
      cyc(); WR_START = 1'b0; #1;
      check("fp_rdreq", FIFO_RDREQ, 1);
      if (i > 0) check("fp_datain", DATAIN, 32'hD000_0000 + i - 1);
    end
    cyc();
    check("fp_done1", DONE, 1);
    check("fp_datain_last", DATAIN, 32'hD000_00FF);
    WR_START = 1'b1; WR_LEN = 9'd1;
    cyc(); WR_START = 1'b0; #1;
    check("fp_b2b_busy", BUSY, 1);
    check("fp_b2b_rdreq", FIFO_RDREQ, 1);
    check("fp_b2b_dm", DM, 4'h0);
    check("fp_b2b_done_low", DONE, 0);
    cyc();
    check("fp_done2", DONE, 1);
    check("fp_datain2", DATAIN, 32'hD000_0100);
    check("fp_pops", pop_cnt - p0, 257);
    check("fp_busy_end", BUSY, 0);

    // Corner cases: zero length, start+abort in idle, start during burst
    WR_START = 1'b1; WR_LEN = 9'd0;
    cyc(); WR_START = 1'b0; #1;
    check("zl_busy", BUSY, 0);
    cyc();
    check("zl_done", DONE, 0);
    push(32'hE000_0000);
    WR_START = 1'b1; WR_LEN = 9'd4; WR_ABORT = 1'b1;
    cyc(); WR_START = 1'b0; WR_ABORT = 1'b0; #1;
    check("sa_busy", BUSY, 0);
    check("sa_rdreq", FIFO_RDREQ, 0);
    push(32'hE000_0001); push(32'hE000_0002); push(32'hE000_0003);
    p0 = pop_cnt;
    WR_START = 1'b1; WR_LEN = 9'd3;
    cyc(); WR_START = 1'b0;
    cyc(); WR_START = 1'b1; WR_LEN = 9'd5;
    cyc(); WR_START = 1'b0;
    cyc();
    check("sb_done", DONE, 1);
    check("sb_busy", BUSY, 0);
    check("sb_pops", pop_cnt - p0, 3);
    check("sb_datain", DATAIN, 32'hE000_0002);
    flush = 1'b1; cyc(); flush = 1'b0;

    // Asynchronous reset during beat 2 of a 6-beat burst
    for (int i = 0; i < 6; i++) push(32'hF000_0000 + i);
    WR_START = 1'b1; WR_LEN = 9'd6;
    cyc(); WR_START = 1'b0;
    cyc(); cyc();
    #2 RESET_N = 1'b0;
    #1;
    check("ar_datain", DATAIN, 0);
    check("ar_dm", DM, 4'hF);
    check("ar_busy", BUSY, 0);
    check("ar_rdreq", FIFO_RDREQ, 0);
    @(posedge CLK); #3 RESET_N = 1'b1;
    flush = 1'b1; cyc(); flush = 1'b0;
    check("ar_no_done", DONE, 0);
    push(32'h1234_0000); push(32'h1234_0001);
    WR_START = 1'b1; WR_LEN = 9'd2;
    cyc(); WR_START = 1'b0; #1;
    check("ar2_rdreq", FIFO_RDREQ, 1);
    cyc();
    check("ar2_datain0", DATAIN, 32'h1234_0000);
    cyc();
    check("ar2_datain1", DATAIN, 32'h1234_0001);
    check("ar2_done", DONE, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
